// File: rtl/ascii_dec_accumulator_if.sv
// Character-stream and result bus for the ASCII decimal accumulator.
interface ascii_dec_accumulator_if #(
  parameter int WIDTH      = 16,
  parameter int MAX_DIGITS = 5
);
  localparam int CW = $clog2(MAX_DIGITS + 1);

  logic             clear;
  logic             char_valid;
  logic [7:0]       char_data;
  logic             char_ready;
  logic [WIDTH-1:0] value;
  logic             value_valid;
  logic             err;
  logic [1:0]       err_code;
  logic             ack;
  logic [CW-1:0]    digit_cnt;

  modport master (
    output clear, char_valid, char_data, ack,
    input  char_ready, value, value_valid, err, err_code, digit_cnt
  );

  modport slave (
    input  clear, char_valid, char_data, ack,
    output char_ready, value, value_valid, err, err_code, digit_cnt
  );
endinterface

// File: rtl/ascii_dec_accumulator.sv
// Builds an unsigned binary value from a stream of ASCII decimal digits
// (acc = acc*10 + d); reports the result on a terminator or flags an error.
//
// state | meaning
// IDLE  | waiting for the first digit; terminators are ignored
// ACCUM | at least one digit accepted, accumulating
// DONE  | value_valid held until ack
// ERROR | err/err_code held until ack
module ascii_dec_accumulator #(
  parameter int WIDTH        = 16,
  parameter int MAX_DIGITS   = 5,
  parameter int IGNORE_SPACE = 1
) (
  input logic clk,
  input logic rst,
  ascii_dec_accumulator_if.slave bus
);
  localparam int CW = $clog2(MAX_DIGITS + 1);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE, ERROR} state_t;

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] value_q;
  logic             value_valid_q;
  logic             err_q;
  logic [1:0]       err_code_q;

  logic [3:0]       digit;
  logic             is_digit, is_term, is_space, skip_space;
  logic             take;
  logic [WIDTH+3:0] acc_ext;
  logic [WIDTH+3:0] acc_x10;
  logic             ovf;

  assign digit      = bus.char_data[3:0];
  assign is_digit   = (bus.char_data >= 8'h30) && (bus.char_data <= 8'h39);
  assign is_term    = (bus.char_data == 8'h0D) || (bus.char_data == 8'h2B) ||
                      (bus.char_data == 8'h3D);
  assign is_space   = (bus.char_data == 8'h20);
  assign skip_space = is_space && (IGNORE_SPACE != 0);

  assign bus.char_ready = (state == IDLE) || (state == ACCUM);
  assign take           = bus.char_valid && bus.char_ready;

  // Widened by 4 bits so acc*10+9 can never wrap before the overflow test
  assign acc_ext = {4'b0000, acc};
  assign acc_x10 = (acc_ext << 3) + (acc_ext << 1) + {{WIDTH{1'b0}}, digit};
  assign ovf     = (acc_x10[WIDTH+3:WIDTH] != 4'd0) || (cnt == CW'(MAX_DIGITS));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      acc           <= '0;
      cnt           <= '0;
      value_q       <= '0;
      value_valid_q <= 1'b0;
      err_q         <= 1'b0;
      err_code_q    <= 2'b00;
    end else if (bus.clear) begin
      state         <= IDLE;
      acc           <= '0;
      cnt           <= '0;
      value_valid_q <= 1'b0;
      err_q         <= 1'b0;
      err_code_q    <= 2'b00;
    end else begin
      case (state)
        IDLE, ACCUM: begin
          if (take) begin
            if (is_digit) begin
              if (state == IDLE) begin
                state <= ACCUM;
                acc   <= {{(WIDTH-4){1'b0}}, digit};
                cnt   <= CW'(1);
              end else if (ovf) begin
                state      <= ERROR;
                err_q      <= 1'b1;
                err_code_q <= 2'b10;
              end else begin
                acc <= acc_x10[WIDTH-1:0];
                cnt <= cnt + CW'(1);
              end
            end else if (is_term) begin
              if (state == ACCUM) begin
                state         <= DONE;
                value_q       <= acc;
                value_valid_q <= 1'b1;
              end
            end else if (!skip_space) begin
              state      <= ERROR;
              err_q      <= 1'b1;
              err_code_q <= 2'b01;
            end
          end
        end
        DONE: begin
          if (bus.ack) begin
            state         <= IDLE;
            acc           <= '0;
            cnt           <= '0;
            value_valid_q <= 1'b0;
          end
        end
        ERROR: begin
          if (bus.ack) begin
            state      <= IDLE;
            acc        <= '0;
            cnt        <= '0;
            err_q      <= 1'b0;
            err_code_q <= 2'b00;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.value       = value_q;
  assign bus.value_valid = value_valid_q;
  assign bus.err         = err_q;
  assign bus.err_code    = err_code_q;
  assign bus.digit_cnt   = cnt;
endmodule

// File: tb/tb_ascii_dec_accumulator.sv
// Drives two differently configured accumulators with one character stream
// and compares every output against a behavioural model after each edge.
module tb_ascii_dec_accumulator;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ascii_dec_accumulator_if #(.WIDTH(16), .MAX_DIGITS(5)) ifa ();
  ascii_dec_accumulator_if #(.WIDTH(8),  .MAX_DIGITS(3)) ifb ();

  ascii_dec_accumulator #(.WIDTH(16), .MAX_DIGITS(5), .IGNORE_SPACE(1)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa));
  ascii_dec_accumulator #(.WIDTH(8), .MAX_DIGITS(3), .IGNORE_SPACE(0)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb));

  // Model: phase 0 idle, 1 accumulating, 2 result held, 3 error held
  int cfg_w[2]    = '{16, 8};
  int cfg_max[2]  = '{5, 3};
  int cfg_ign[2]  = '{1, 0};
  int ph[2], macc[2], nd[2], mval[2], mvv[2], mer[2], mec[2];

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      ph[k] = 0; macc[k] = 0; nd[k] = 0; mval[k] = 0;
      mvv[k] = 0; mer[k] = 0; mec[k] = 0;
    end
  endfunction

  function automatic void model_step(int k, logic v, logic [7:0] c, logic a, logic cl);
    int d;
    if (cl) begin
      ph[k] = 0; macc[k] = 0; nd[k] = 0; mvv[k] = 0; mer[k] = 0; mec[k] = 0;
    end else if (ph[k] == 2) begin
      if (a) begin ph[k] = 0; macc[k] = 0; nd[k] = 0; mvv[k] = 0; end
    end else if (ph[k] == 3) begin
      if (a) begin ph[k] = 0; macc[k] = 0; nd[k] = 0; mer[k] = 0; mec[k] = 0; end
    end else if (v) begin
      if (c >= "0" && c <= "9") begin
        d = int'(c) - 48;
        if (ph[k] == 0) begin
          ph[k] = 1; macc[k] = d; nd[k] = 1;
        end else if (nd[k] == cfg_max[k] || macc[k] * 10 + d > (1 << cfg_w[k]) - 1) begin
          ph[k] = 3; mer[k] = 1; mec[k] = 2;
        end else begin
          macc[k] = macc[k] * 10 + d; nd[k] = nd[k] + 1;
        end
      end else if (c == 8'h0D || c == "+" || c == "=") begin
        if (ph[k] == 1) begin ph[k] = 2; mval[k] = macc[k]; mvv[k] = 1; end
      end else if (c == " " && cfg_ign[k] != 0) begin
        // consumed silently
      end else begin
        ph[k] = 3; mer[k] = 1; mec[k] = 1;
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("a.value",       32'(ifa.value),       mval[0]);
    chk("a.value_valid", 32'(ifa.value_valid), mvv[0]);
    chk("a.err",         32'(ifa.err),         mer[0]);
    chk("a.err_code",    32'(ifa.err_code),    mec[0]);
    chk("a.digit_cnt",   32'(ifa.digit_cnt),   nd[0]);
    chk("a.char_ready",  32'(ifa.char_ready),  (ph[0] < 2) ? 1 : 0);
    chk("b.value",       32'(ifb.value),       mval[1]);
    chk("b.value_valid", 32'(ifb.value_valid), mvv[1]);
    chk("b.err",         32'(ifb.err),         mer[1]);
    chk("b.err_code",    32'(ifb.err_code),    mec[1]);
    chk("b.digit_cnt",   32'(ifb.digit_cnt),   nd[1]);
    chk("b.char_ready",  32'(ifb.char_ready),  (ph[1] < 2) ? 1 : 0);
  endtask

  // Present inputs one step after an edge, clock once, then compare
  task automatic step(input logic v, input logic [7:0] c, input logic a, input logic cl);
    ifa.char_valid = v; ifa.char_data = c; ifa.ack = a; ifa.clear = cl;
    ifb.char_valid = v; ifb.char_data = c; ifb.ack = a; ifb.clear = cl;
    @(posedge clk);
    model_step(0, v, c, a, cl);
    model_step(1, v, c, a, cl);
    #1;
    check_all();
  endtask

  task automatic send(input logic [7:0] c);
    step(1'b1, c, 1'b0, 1'b0);
  endtask

  task automatic idle_ack();
    step(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all();
    #1 rst = 1'b0;
  endtask

  initial begin
    logic [7:0] ch;
    int r;
    ifa.char_valid = 0; ifa.char_data = 0; ifa.ack = 0; ifa.clear = 0;
    ifb.char_valid = 0; ifb.char_data = 0; ifb.ack = 0; ifb.clear = 0;
    model_reset();
    #12;
    check_all();
    rst = 1'b0;
    @(posedge clk); #1;

    // 123 CR: A reports 123; B's 8-bit/3-digit config also gives 123
    send("1"); send("2"); send("3"); send(8'h0D);
    chk("a.value_123", 32'(ifa.value), 123);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("a.held_123", 32'(ifa.value_valid), 1);
    idle_ack();

    // 255 legal max for B; 256 overflows on the third digit
    send("2"); send("5"); send("5"); send("+");
    chk("b.value_255", 32'(ifb.value), 255);
    idle_ack();
    send("2"); send("5"); send("6");
    chk("b.ovf_code", 32'(ifb.err_code), 2);
    send("7");
    idle_ack();

    // Leading zeros count as digits: B overflows on the fourth
    send("0"); send("0"); send("0"); send("1");
    chk("b.ovf_digits", 32'(ifb.err_code), 2);
    idle_ack();
    send("A");
    chk("a.invalid", 32'(ifa.err_code), 1);
    idle_ack();

    // 65535 legal for A, 65536 and a sixth digit overflow
    send("6"); send("5"); send("5"); send("3"); send("5"); send("=");
    chk("a.value_max", 32'(ifa.value), 65535);
    idle_ack(); idle_ack();
    send("6"); send("5"); send("5"); send("3"); send("6");
    chk("a.ovf_value", 32'(ifa.err_code), 2);
    idle_ack();
    send("0"); send("0"); send("0"); send("0"); send("1"); send("2");
    chk("a.ovf_digits", 32'(ifa.err_code), 2);
    idle_ack();

    // Backpressure: '9' held through DONE, accepted only after ack
    send("7"); send("=");
    step(1'b1, "9", 1'b0, 1'b0);
    step(1'b1, "9", 1'b1, 1'b0);
    send("9");
    chk("a.bp_cnt", 32'(ifa.digit_cnt), 1);
    send(8'h0D);
    chk("a.bp_value", 32'(ifa.value), 9);
    idle_ack();

    // Asynchronous reset mid-number, then clear beside a valid digit
    send("4"); send("5");
    async_reset();
    send("7"); send(8'h0D);
    chk("a.after_rst", 32'(ifa.value), 7);
    idle_ack();
    step(1'b1, "8", 1'b0, 1'b1);
    chk("a.clear_drop", 32'(ifa.digit_cnt), 0);
    send("3"); step(1'b1, "8", 1'b0, 1'b1);
    idle_ack();

    // Spaces: skipped by A, an error for B
    send("1"); send(" "); send("2"); send(8'h0D);
    chk("a.space_val", 32'(ifa.value), 12);
    chk("b.space_err", 32'(ifb.err_code), 1);
    idle_ack();

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 19);
      if (r < 12)       ch = 8'(8'h30 + $urandom_range(0, 9));
      else if (r == 12) ch = 8'h0D;
      else if (r == 13) ch = "+";
      else if (r == 14) ch = "=";
      else if (r == 15) ch = " ";
      else if (r == 16) ch = 8'(8'h41 + $urandom_range(0, 25));
      else              ch = 8'($urandom_range(0, 255));
      step($urandom_range(0, 3) != 0, ch, $urandom_range(0, 3) == 0,
           $urandom_range(0, 59) == 0);
      if ($urandom_range(0, 299) == 0) async_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ascii_dec_accumulator.md
Name: ascii_dec_accumulator

Overview:
- Sequential, parametrised successor to the combinational BCD ×10 digit stage.
- Accepts a stream of ASCII characters over a valid/ready handshake and builds an unsigned binary value digit by digit: acc = acc×10 + digit.
- Presents the result on a terminator character, or flags an error.
- Sits between the keyboard/UART character front end and the binary adder datapath; one instance per operand.

Parameters:
- WIDTH, 16, bit width of the accumulated binary value (min 4).
- MAX_DIGITS, 5, maximum decimal digits accepted per number, leading zeros included.
- IGNORE_SPACE, 1, when 1 the ASCII space (0x20) is silently consumed; when 0 it is an invalid character.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- clear  input  1  synchronous abort; returns the block to IDLE
- char_valid  input  1  char_data is valid this cycle
- char_data  input  8  ASCII character
- char_ready  output  1  block accepts a character this cycle
- value  output  WIDTH  accumulated binary result
- value_valid  output  1  result available, held until ack
- err  output  1  error condition, held until ack
- err_code  output  2  01 invalid char, 10 overflow, 00 none
- ack  input  1  consumer acknowledges value_valid or err
- digit_cnt  output  $clog2(MAX_DIGITS+1)  digits accepted so far

Behaviour:
- Reset (async, rst=1): state=IDLE, acc=0, value=0, value_valid=0, err=0, err_code=00, digit_cnt=0. Handshakes presented while rst=1 are ignored.
- States: IDLE, ACCUM, DONE, ERROR. char_ready=1 in IDLE and ACCUM, 0 in DONE and ERROR; decoded from state.
- Transfer: occurs on a clk edge with char_valid && char_ready.
- Character classes:
  - digit: 0x30–0x39, d = char_data[3:0]
  - terminator: 0x0D CR, 0x2B '+', 0x3D '='
  - space: 0x20
  - all others invalid
- ×10 arithmetic: computed as (acc<<3)+(acc<<1)+d in WIDTH+4 bits. Overflow if the result exceeds 2^WIDTH−1, or if digit_cnt would exceed MAX_DIGITS.
- IDLE:
  - digit → ACCUM, acc=d, digit_cnt=1
  - terminator → ignored, stay IDLE, no output
  - space → ignored if IGNORE_SPACE, else ERROR/01
  - invalid → ERROR, err_code=01
- ACCUM:
  - digit without overflow → acc updated, digit_cnt+1
  - digit with overflow → ERROR, err_code=10; acc not updated
  - terminator → DONE, value=acc
  - space → ignored if IGNORE_SPACE, else ERROR/01
  - invalid → ERROR/01
- Latency: the terminator transfer on edge N gives value_valid=1 after edge N, visible in cycle N+1. Errors follow the same one-edge latency.
- DONE: value_valid=1 and value stable until ack=1 is sampled. On that edge: IDLE, acc=0, digit_cnt=0, value_valid=0. value keeps its last result.
- ERROR: err=1 with err_code stable until ack is sampled. On that edge: IDLE, err=0, err_code=00, acc=0, digit_cnt=0.
- ack in IDLE/ACCUM: no effect.
- clear: highest synchronous priority. Any state → IDLE, acc=0, digit_cnt=0, value_valid=0, err=0. A transfer in the same cycle is dropped, even though char_ready is high.
- Mid-operation reset: asynchronous return to reset values; a partial number is discarded.
- Boundaries:
  - Exactly 2^WIDTH−1 is legal.
  - Exactly MAX_DIGITS digits is legal; the next digit overflows.
  - A leading '0' counts as a digit.

Test Plan:
- WIDTH=16: '1','2','3',CR → value=123 (0x007B), value_valid high one cycle after CR, held until ack; then IDLE, digit_cnt=0.
- WIDTH=8, MAX_DIGITS=3: '2','5','5','+' → value=255; then '2','5','6' → err=1, err_code=10 after '6', char_ready=0 until ack.
- MAX_DIGITS=3: '0','0','0','1' → overflow on fourth digit. Then 'A' in IDLE → err_code=01.
- Backpressure: after '7','=' hold char_valid with '9' during DONE → not accepted (char_ready=0); ack → '9' accepted next cycle, ACCUM acc=9.
- Reset/clear: '4','5' then rst pulse mid-cycle → all outputs 0 immediately; '7',CR → value=7. clear asserted together with a valid '8' → '8' dropped, state IDLE.
- Spaces: IGNORE_SPACE=1, '1',' ','2',CR → 12. IGNORE_SPACE=0, same stream → err_code=01 on the space.
